// File: rtl/core_inst_seq_if.sv
// Host/core-side bundle for the instruction sequencer: pass configuration,
// start strobe, OFIFO back-pressure in, instruction word and status out.
interface core_inst_seq_if #(
    parameter int addr_w = 11
);
    logic              start;
    logic [addr_w-1:0] w_base;
    logic [addr_w-1:0] x_base;
    logic [addr_w-1:0] p_base;
    logic [addr_w-1:0] n_act;
    logic              acc_mode;
    logic              ofifo_valid;
    logic [33:0]       inst;
    logic              busy;
    logic              done;

    // Controller / bench side: issues passes and models the OFIFO.
    modport master (
        output start, w_base, x_base, p_base, n_act, acc_mode, ofifo_valid,
        input  inst, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, w_base, x_base, p_base, n_act, acc_mode, ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one core tile pass:
// weight fetch -> weight load -> array drain -> activation fetch -> execute
// -> execute drain -> OFIFO-to-pmem drain -> done.
// Every output is a register; the word seen in a cycle was computed from the
// state/counter values that cycle will hold, at the edge that starts it.
module core_inst_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11
) (
    input logic           clk,
    input logic           reset,
    core_inst_seq_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WFETCH = 4'd1,
        S_WLOAD  = 4'd2,
        S_WDRAIN = 4'd3,
        S_XFETCH = 4'd4,
        S_EXEC   = 4'd5,
        S_EDRAIN = 4'd6,
        S_DRAIN  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    // Quiescent word: both memories disabled and write-protected.
    localparam logic [33:0]       IDLE_WORD = 34'h1_800C_0000;
    localparam logic [addr_w-1:0] ZERO_A    = {addr_w{1'b0}};
    localparam logic [addr_w-1:0] ONE_A     = addr_w'(1);
    localparam logic [addr_w-1:0] COL_A     = addr_w'(col);
    localparam logic [addr_w-1:0] COL_M1_A  = addr_w'(col - 1);
    localparam logic [addr_w-1:0] DRN_M1_A  = addr_w'(row + col - 1);

    // Instruction field positions.
    localparam int B_ACC   = 33;
    localparam int B_CEN_P = 32;
    localparam int B_WEN_P = 31;
    localparam int B_CEN_X = 19;
    localparam int B_OF_RD = 6;
    localparam int B_L0_RD = 3;
    localparam int B_L0_WR = 2;
    localparam int B_EXEC  = 1;
    localparam int B_LOAD  = 0;

    state_t            r_state;
    logic [addr_w-1:0] r_cnt;
    logic [addr_w-1:0] r_idx;
    logic [addr_w-1:0] r_w_base;
    logic [addr_w-1:0] r_x_base;
    logic [addr_w-1:0] r_p_base;
    logic [addr_w-1:0] r_n_act;
    logic              r_acc;
    logic [33:0]       r_inst;
    logic              r_busy;
    logic              r_done;

    state_t            w_nxt_state;
    logic [addr_w-1:0] w_nxt_cnt;
    logic [addr_w-1:0] w_nxt_idx;
    logic              w_pop;
    logic [33:0]       w_nxt_inst;
    logic [addr_w-1:0] w_w_base;
    logic [addr_w-1:0] w_x_base;
    logic [addr_w-1:0] w_p_base;
    logic [addr_w-1:0] w_n_act;
    logic              w_acc;
    logic              w_start_ok;

    // Builds the instruction word for a given upcoming state and counter.
    function automatic logic [33:0] make_word(
        input state_t            st,
        input logic [addr_w-1:0] cnt,
        input logic              pop,
        input logic [addr_w-1:0] idx,
        input logic              acc,
        input logic [addr_w-1:0] wb,
        input logic [addr_w-1:0] xb,
        input logic [addr_w-1:0] pb,
        input logic [addr_w-1:0] n
    );
        logic [33:0]       w;
        logic [addr_w-1:0] a;
        w = IDLE_WORD;
        a = ZERO_A;
        if (st != S_IDLE) begin
            w[B_ACC] = acc;
        end else begin
            w[B_ACC] = 1'b0;
        end
        case (st)
            S_WFETCH, S_XFETCH: begin
                // Read phase runs cnt 0..depth-1; L0 write trails by one
                // cycle to cover the xmem read latency.
                if (cnt < ((st == S_WFETCH) ? COL_A : n)) begin
                    a           = ((st == S_WFETCH) ? wb : xb) + cnt;
                    w[B_CEN_X]  = 1'b0;
                    w[17:7]     = 11'(a);
                end else begin
                    w[B_CEN_X]  = 1'b1;
                end
                if (cnt != ZERO_A) begin
                    w[B_L0_WR] = 1'b1;
                end else begin
                    w[B_L0_WR] = 1'b0;
                end
            end
            S_WLOAD: begin
                w[B_L0_RD] = 1'b1;
                w[B_LOAD]  = 1'b1;
            end
            S_EXEC: begin
                w[B_L0_RD] = 1'b1;
                w[B_EXEC]  = 1'b1;
            end
            S_EDRAIN: begin
                w[B_EXEC] = 1'b1;
            end
            S_DRAIN: begin
                if (pop) begin
                    a          = pb + idx;
                    w[B_CEN_P] = 1'b0;
                    w[B_WEN_P] = 1'b0;
                    w[30:20]   = 11'(a);
                    w[B_OF_RD] = 1'b1;
                end else begin
                    w[B_OF_RD] = 1'b0;
                end
            end
            default: begin
                w[B_LOAD] = 1'b0;
            end
        endcase
        return w;
    endfunction

    // Config seen by this edge: live inputs when launching a pass, latched copy otherwise.
    always_comb begin
        w_start_ok = (r_state == S_IDLE) && bus.start;
        if (r_state == S_IDLE) begin
            w_w_base = bus.w_base;
            w_x_base = bus.x_base;
            w_p_base = bus.p_base;
            w_n_act  = bus.n_act;
            w_acc    = bus.acc_mode;
        end else begin
            w_w_base = r_w_base;
            w_x_base = r_x_base;
            w_p_base = r_p_base;
            w_n_act  = r_n_act;
            w_acc    = r_acc;
        end
    end

    // Next-state, cycle counter and drained-entry counter.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + ONE_A;
        w_nxt_idx   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nxt_cnt = ZERO_A;
                w_nxt_idx = ZERO_A;
                if (bus.start) begin
                    w_nxt_state = S_WFETCH;
                end else begin
                    w_nxt_state = S_IDLE;
                end
            end
            S_WFETCH: begin
                if (r_cnt == COL_A) begin
                    w_nxt_state = S_WLOAD;
                    w_nxt_cnt   = ZERO_A;
                end else begin
                    w_nxt_state = S_WFETCH;
                end
            end
            S_WLOAD: begin
                if (r_cnt == COL_M1_A) begin
                    w_nxt_state = S_WDRAIN;
                    w_nxt_cnt   = ZERO_A;
                end else begin
                    w_nxt_state = S_WLOAD;
                end
            end
            S_WDRAIN: begin
                if (r_cnt == DRN_M1_A) begin
                    w_nxt_cnt = ZERO_A;
                    if (r_n_act == ZERO_A) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_state = S_XFETCH;
                    end
                end else begin
                    w_nxt_state = S_WDRAIN;
                end
            end
            S_XFETCH: begin
                if (r_cnt == r_n_act) begin
                    w_nxt_state = S_EXEC;
                    w_nxt_cnt   = ZERO_A;
                end else begin
                    w_nxt_state = S_XFETCH;
                end
            end
            S_EXEC: begin
                if (r_cnt == (r_n_act - ONE_A)) begin
                    w_nxt_state = S_EDRAIN;
                    w_nxt_cnt   = ZERO_A;
                end else begin
                    w_nxt_state = S_EXEC;
                end
            end
            S_EDRAIN: begin
                if (r_cnt == DRN_M1_A) begin
                    w_nxt_state = S_DRAIN;
                    w_nxt_cnt   = ZERO_A;
                end else begin
                    w_nxt_state = S_EDRAIN;
                end
            end
            S_DRAIN: begin
                w_nxt_cnt = ZERO_A;
                if (r_idx == r_n_act) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_DRAIN;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = ZERO_A;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_cnt   = ZERO_A;
                w_nxt_idx   = ZERO_A;
            end
        endcase
        // A pop is issued in a DRAIN cycle only if the FWFT head was valid
        // when that cycle's word was registered.
        if ((w_nxt_state == S_DRAIN) && bus.ofifo_valid) begin
            w_pop     = 1'b1;
            w_nxt_idx = r_idx + ONE_A;
        end else begin
            w_pop     = 1'b0;
        end
    end

    // Word for the upcoming cycle.
    always_comb begin
        w_nxt_inst = make_word(w_nxt_state, w_nxt_cnt, w_pop, r_idx, w_acc,
                               w_w_base, w_x_base, w_p_base, w_n_act);
    end

    // Sequencer state, counters, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= ZERO_A;
            r_idx    <= ZERO_A;
            r_w_base <= ZERO_A;
            r_x_base <= ZERO_A;
            r_p_base <= ZERO_A;
            r_n_act  <= ZERO_A;
            r_acc    <= 1'b0;
            r_inst   <= IDLE_WORD;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_idx   <= w_nxt_idx;
            r_inst  <= w_nxt_inst;
            r_busy  <= (w_nxt_state != S_IDLE);
            r_done  <= (w_nxt_state == S_DONE);
            if (w_start_ok) begin
                r_w_base <= bus.w_base;
                r_x_base <= bus.x_base;
                r_p_base <= bus.p_base;
                r_n_act  <= bus.n_act;
                r_acc    <= bus.acc_mode;
            end else begin
                r_w_base <= r_w_base;
                r_x_base <= r_x_base;
                r_p_base <= r_p_base;
                r_n_act  <= r_n_act;
                r_acc    <= r_acc;
            end
        end
    end

    assign bus.inst = r_inst;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_core_inst_seq.sv
// Scoreboard bench for core_inst_seq: each pass pushes its hand-derived word
// stream into a queue; a negedge monitor compares every busy cycle against it.
module tb_core_inst_seq;

    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    typedef struct packed {
        logic [33:0] inst;
        logic        done;
    } exp_t;

    logic  clk;
    logic  reset;
    exp_t  q[$];
    int    n_checks;
    int    n_pass;
    string cur;

    core_inst_seq_if #(.addr_w(11)) bus ();

    core_inst_seq #(.row(8), .col(8), .addr_w(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // OFIFO valid seen at the edge that produces busy cycle k.
    function automatic logic pat(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return (k % 2) == 1;
    endfunction

    task automatic push(input logic [33:0] w, input logic d);
        exp_t e;
        e.inst = w;
        e.done = d;
        q.push_back(e);
    endtask

    // Expected word stream for one pass with row=col=8.
    task automatic build(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                         input logic [10:0] n, input logic acc, input int mode);
        logic [33:0] w;
        logic [10:0] a;
        int k;
        int i;
        k = 0;
        for (int c = 0; c <= 8; c++) begin
            w = IDLE_W; w[33] = acc;
            if (c < 8) begin a = wb + 11'(c); w[19] = 1'b0; w[17:7] = a; end
            if (c >= 1) w[2] = 1'b1;
            push(w, 1'b0); k++;
        end
        for (int c = 0; c < 8; c++) begin
            w = IDLE_W; w[33] = acc; w[3] = 1'b1; w[0] = 1'b1;
            push(w, 1'b0); k++;
        end
        for (int c = 0; c < 16; c++) begin
            w = IDLE_W; w[33] = acc;
            push(w, 1'b0); k++;
        end
        if (n != 11'd0) begin
            for (int c = 0; c <= int'(n); c++) begin
                w = IDLE_W; w[33] = acc;
                if (c < int'(n)) begin a = xb + 11'(c); w[19] = 1'b0; w[17:7] = a; end
                if (c >= 1) w[2] = 1'b1;
                push(w, 1'b0); k++;
            end
            for (int c = 0; c < int'(n); c++) begin
                w = IDLE_W; w[33] = acc; w[3] = 1'b1; w[1] = 1'b1;
                push(w, 1'b0); k++;
            end
            for (int c = 0; c < 16; c++) begin
                w = IDLE_W; w[33] = acc; w[1] = 1'b1;
                push(w, 1'b0); k++;
            end
            i = 0;
            while (i < int'(n)) begin
                w = IDLE_W; w[33] = acc;
                if (pat(mode, k)) begin
                    a = pb + 11'(i);
                    w[32] = 1'b0; w[31] = 1'b0; w[30:20] = a; w[6] = 1'b1;
                    i++;
                end
                push(w, 1'b0); k++;
            end
        end
        w = IDLE_W; w[33] = acc;
        push(w, 1'b1);
    endtask

    // Monitor: every busy cycle consumes and checks one expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                if (q.size() == 0) begin
                    chk({cur, "_underflow"}, 64'(q.size()), 64'd1);
                end else begin
                    e = q.pop_front();
                    chk({cur, "_inst"}, 64'(bus.inst), 64'(e.inst));
                    chk({cur, "_done"}, 64'(bus.done), 64'(e.done));
                end
            end
        end
    end

    // Runs one pass; optional mid-pass start/config scramble, start in DONE, reset.
    task automatic run_pass(input string nm, input logic [10:0] wb, input logic [10:0] xb,
                            input logic [10:0] pb, input logic [10:0] n, input logic acc,
                            input int mode, input int exp_cycles, input int exp_left,
                            input int mid_k, input int done_k, input int rst_k);
        int k;
        q.delete();
        cur = nm;
        build(wb, xb, pb, n, acc, mode);
        @(negedge clk);
        bus.w_base = wb; bus.x_base = xb; bus.p_base = pb; bus.n_act = n;
        bus.acc_mode = acc; bus.start = 1'b1; bus.ofifo_valid = pat(mode, 0);
        k = 0;
        @(negedge clk);
        while ((bus.busy === 1'b1) && (k < 1000)) begin
            bus.start = 1'b0;
            if (k == mid_k) begin
                bus.start = 1'b1;
                bus.w_base = 11'd500; bus.x_base = 11'd600; bus.p_base = 11'd700;
                bus.n_act = 11'd99; bus.acc_mode = ~acc;
            end
            if (k == done_k) bus.start = 1'b1;
            if (k == rst_k) reset = 1'b1;
            bus.ofifo_valid = pat(mode, k + 1);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        chk({nm, "_busy_cycles"}, 64'(k), 64'(exp_cycles));
        chk({nm, "_queue_left"}, 64'(q.size()), 64'(exp_left));
        @(negedge clk);
        chk({nm, "_idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cur      = "reset";
        reset    = 1'b1;
        bus.start = 1'b0; bus.w_base = 11'd0; bus.x_base = 11'd0; bus.p_base = 11'd0;
        bus.n_act = 11'd0; bus.acc_mode = 1'b0; bus.ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_inst", 64'(bus.inst), 64'(IDLE_W));
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal pass, OFIFO always valid: 9+8+16+37+36+16+36+1.
        run_pass("nominal", 11'd0, 11'd16, 11'd0, 11'd36, 1'b0, 0, 159, 0, -1, -1, -1);
        // Toggling OFIFO valid: DRAIN stretches to 72 cycles.
        run_pass("toggle", 11'd100, 11'd300, 11'd1000, 11'd36, 1'b1, 1, 195, 0, -1, -1, -1);
        // Address wrap on xmem weight/activation and pmem.
        run_pass("wrap", 11'd2044, 11'd2045, 11'd2046, 11'd4, 1'b0, 0, 63, 0, -1, -1, -1);
        // n_act=0 with a start pulse mid-pass and another during DONE.
        run_pass("nact0", 11'd7, 11'd9, 11'd11, 11'd0, 1'b1, 0, 34, 0, 5, 33, -1);
        // Reset asserted for the edge leaving WLOAD cnt=3 (busy cycle 12).
        run_pass("rst_wload", 11'd3, 11'd30, 11'd50, 11'd1, 1'b0, 0, 13, 41, -1, -1, 12);
        chk("rst_inst", 64'(bus.inst), 64'(IDLE_W));
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(bus.inst), 64'(IDLE_W));
        end
        // Recovery pass after the mid-pass reset.
        run_pass("recover", 11'd20, 11'd40, 11'd5, 11'd1, 1'b1, 0, 54, 0, -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
